screen_lane_arbiter: RTL and testbench

SCREEN_LANE_ARBITER -- requirements
Module: screen_lane_arbiter

---
 rtl/screen_lane_arbiter.sv | 143 ++++++++++++++
 tb/tb_screen_lane_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/screen_lane_arbiter.sv
// Round-robin arbiter that funnels four parse lanes into one screening beat stream,
// with a forced idle gap between packets. Optional packet timeout: SCREEN_ARB_TIMEOUT_EN.
module screen_lane_arbiter #(
  parameter int LANES      = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [255:0] i_lane_data,
  input  logic [3:0]   i_lane_valid,
  input  logic [3:0]   i_lane_last,
  input  logic [11:0]  i_lane_flow_type,
  input  logic [31:0]  i_lane_flow_id,
  output logic [3:0]   o_lane_ready,
  output logic [63:0]  o_parse_data,
  output logic         o_pattern_match_valid,
  output logic [2:0]   o_flow_type,
  output logic [7:0]   o_flow_id,
  output logic         o_flow_type_id_valid,
  output logic [1:0]   o_grant_lane,
  output logic         o_abort
);

  if (GAP_CYCLES < 3 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("GAP_CYCLES out of range");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_tmo
    $error("TIMEOUT out of range");
  end

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_ptr;
  logic [1:0]  r_grant;
  logic [2:0]  r_ftype;
  logic [7:0]  r_fid;
  logic        r_fvalid;
  logic [63:0] r_data;
  logic        r_pmv;
  logic [3:0]  r_gap_cnt;
  logic [1:0]  w_win;
  logic [1:0]  w_idx;
  logic        w_acc;
  logic        w_acc_last;
  logic        w_tmo;

  // Scan from ptr+1 downwards in priority so the nearest requester is assigned last.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int i = LANES; i >= 1; i--) begin
      w_idx = r_ptr + 2'(i);
      if (i_lane_valid[w_idx]) w_win = w_idx;
    end
  end

  assign w_acc      = (r_state == S_XFER) && i_lane_valid[r_grant];
  assign w_acc_last = w_acc && i_lane_last[r_grant];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|i_lane_valid) w_next = S_XFER;
      S_XFER:  if (w_acc_last || w_tmo) w_next = S_GAP;
      S_GAP:   if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd3;
      r_grant   <= '0;
      r_ftype   <= '0;
      r_fid     <= '0;
      r_fvalid  <= 1'b0;
      r_data    <= '0;
      r_pmv     <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_pmv     <= w_acc;
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 4'd1 : 4'd0;
      if (w_acc) r_data <= i_lane_data[{r_grant, 6'b0} +: 64];
      case (r_state)
        S_IDLE: begin
          if (|i_lane_valid) begin
            r_grant  <= w_win;
            r_ftype  <= i_lane_flow_type[3*w_win +: 3];
            r_fid    <= i_lane_flow_id[{w_win, 3'b0} +: 8];
            r_fvalid <= 1'b1;
          end
        end
        // The window stays up through the cycle that forwards the last beat.
        S_XFER: begin
          if (w_acc_last || w_tmo) r_ptr <= r_grant;
          if (w_tmo) r_fvalid <= 1'b0;
        end
        default: r_fvalid <= 1'b0;
      endcase
    end
  end

`ifdef SCREEN_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_tmo_cnt;
  logic       r_abort;

  assign w_tmo = (r_state == S_XFER) && !w_acc && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
      r_abort   <= 1'b0;
    end else begin
      r_abort <= w_tmo;
      if (r_state != S_XFER || w_acc) r_tmo_cnt <= '0;
      else                            r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  assign o_abort = r_abort;
`else
  assign w_tmo   = 1'b0;
  assign o_abort = 1'b0;
`endif

  assign o_lane_ready          = (r_state == S_XFER) ? (4'b0001 << r_grant) : 4'b0000;
  assign o_parse_data          = r_data;
  assign o_pattern_match_valid = r_pmv;
  assign o_flow_type           = r_ftype;
  assign o_flow_id             = r_fid;
  assign o_flow_type_id_valid  = r_fvalid;
  assign o_grant_lane          = r_grant;

endmodule

// File: tb/tb_screen_lane_arbiter.sv
// Randomized bench for screen_lane_arbiter: lane drivers fed from per-lane packet
// queues, checked against a transaction-level round-robin / gap / forwarding model.
module tb_screen_lane_arbiter;

  localparam int GAP = 4;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] lane_data = '0;
  logic [3:0]   lane_valid = '0;
  logic [3:0]   lane_last = '0;
  logic [11:0]  lane_ftype = '0;
  logic [31:0]  lane_fid = '0;
  logic [3:0]   o_lane_ready;
  logic [63:0]  o_parse_data;
  logic         o_pmv;
  logic [2:0]   o_flow_type;
  logic [7:0]   o_flow_id;
  logic         o_fvalid;
  logic [1:0]   o_grant_lane;
  logic         o_abort;

  screen_lane_arbiter #(.LANES(4), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lane_data(lane_data), .i_lane_valid(lane_valid),
    .i_lane_last(lane_last), .i_lane_flow_type(lane_ftype), .i_lane_flow_id(lane_fid),
    .o_lane_ready(o_lane_ready), .o_parse_data(o_parse_data),
    .o_pattern_match_valid(o_pmv), .o_flow_type(o_flow_type), .o_flow_id(o_flow_id),
    .o_flow_type_id_valid(o_fvalid), .o_grant_lane(o_grant_lane), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic l; } beat_t;

  beat_t       bq[4][$];
  logic [10:0] fq[4][$];
  int          hold[4];
  int          vecs = 0, errs = 0;
  int          cyc = 0, mptr = 3, stall_pct = 0, force_gap = 0, freeze_lane = -1;
  int          acc_iter = 0, last_acc_iter = -10, low_run = 0;
  bit          acc_any, pkt_open, first_win, wait_all, abort_armed, abort_run, fv_prev;
  beat_t       acc_beat;
  logic [63:0] last_data;
  logic [10:0] cur_flow;
  logic [3:0]  drv_prev;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic gen_pkt(input int k, input int n, input logic [10:0] fl);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = {$urandom, $urandom};
      b.l = (i == n - 1);
      bq[k].push_back(b);
    end
    fq[k].push_back(fl);
  endtask

  task automatic clear_model();
    mptr = 3; pkt_open = 0; acc_any = 0; last_data = '0; last_acc_iter = -10;
    first_win = 1; fv_prev = 0; low_run = 0; wait_all = 0; abort_armed = 0;
    abort_run = 0; freeze_lane = -1; drv_prev = '0; cur_flow = '0;
    for (int k = 0; k < 4; k++) begin
      bq[k].delete(); fq[k].delete(); hold[k] = 0;
    end
    lane_valid = '0; lane_last = '0; lane_data = '0; lane_ftype = '0; lane_fid = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_pmv", o_pmv, 0);
    check_eq("rst_fvalid", o_fvalid, 0);
    check_eq("rst_ready", o_lane_ready, 0);
    check_eq("rst_data", o_parse_data, 0);
    check_eq("rst_grant", o_grant_lane, 0);
    check_eq("rst_flow", {o_flow_type, o_flow_id}, 0);
    check_eq("rst_abort", o_abort, 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic [3:0] v;
    logic [1:0] exp_g;
    bit found, exp_ab;
    @(negedge clk);
    cyc++;
    exp_ab = 0;
`ifdef SCREEN_ARB_TIMEOUT_EN
    exp_ab = abort_armed && (cyc == acc_iter + 9);
`endif
    check_eq("abort", o_abort, exp_ab);
    if (exp_ab) begin
      pkt_open = 0; abort_armed = 0; abort_run = 1; mptr = freeze_lane;
      bq[freeze_lane].delete(); fq[freeze_lane].delete(); hold[freeze_lane] = 0;
      freeze_lane = -1;
      check_eq("abort_window", o_fvalid, 0);
    end
    check_eq("pmv", o_pmv, acc_any);
    if (acc_any) begin
      check_eq("data", o_parse_data, acc_beat.d);
      check_eq("flow_const", {o_flow_type, o_flow_id}, cur_flow);
      last_data = acc_beat.d;
    end else check_eq("data_hold", o_parse_data, last_data);
    if (o_fvalid && !fv_prev) begin
      found = 0; exp_g = '0;
      for (int i = 1; i <= 4; i++)
        if (!found && drv_prev[(mptr + i) % 4]) begin exp_g = 2'((mptr + i) % 4); found = 1; end
      check_eq("grant_req", found, 1);
      check_eq("grant", o_grant_lane, exp_g);
      if (fq[exp_g].size() > 0) begin
        check_eq("flow_latch", {o_flow_type, o_flow_id}, fq[exp_g][0]);
        cur_flow = fq[exp_g][0];
      end
      if (!first_win) begin
        check_eq("gap_min", low_run >= GAP, 1);
        if (wait_all && !abort_run) check_eq("gap_len", low_run, GAP);
      end
      first_win = 0; abort_run = 0;
    end
    if (cyc == last_acc_iter + 2) check_eq("window_fall", o_fvalid, 0);
    if (pkt_open || acc_any) check_eq("window_open", o_fvalid, 1);
    if (!o_fvalid) check_eq("ready_idle", o_lane_ready, 0);
    else if (o_lane_ready != 0) check_eq("ready_grant", o_lane_ready, 4'b0001 << o_grant_lane);
    if (!o_fvalid) begin
      if (fv_prev) begin low_run = 0; wait_all = 1; end
      low_run++;
    end
    fv_prev = o_fvalid;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (hold[k] > 0) hold[k]--;
      else if (bq[k].size() > 0)
        v[k] = o_lane_ready[k] ? ($urandom_range(99) >= stall_pct) : 1'b1;
      if (bq[k].size() > 0) begin
        lane_data[64*k +: 64] = bq[k][0].d;
        lane_last[k] = bq[k][0].l;
      end
      if (fq[k].size() > 0) {lane_ftype[3*k +: 3], lane_fid[8*k +: 8]} = fq[k][0];
    end
    lane_valid = v;
    drv_prev = v;
    if (!o_fvalid && v == 0) wait_all = 0;
    acc_any = 0;
    for (int k = 0; k < 4; k++) begin
      if (v[k] && o_lane_ready[k]) begin
        acc_any = 1;
        acc_beat = bq[k].pop_front();
        if (acc_beat.l) begin
          void'(fq[k].pop_front());
          mptr = k; last_acc_iter = cyc; pkt_open = 0;
        end else begin
          pkt_open = 1; hold[k] = force_gap;
        end
        if (freeze_lane == k) begin hold[k] = 1000; acc_iter = cyc; abort_armed = 1; end
      end
    end
  endtask

  task automatic run_until_idle(input int maxc);
    int n = 0;
    bit busy = 1;
    while (busy && n < maxc) begin
      step();
      n++;
      busy = o_fvalid;
      for (int k = 0; k < 4; k++) if (bq[k].size() > 0) busy = 1;
    end
    if (busy) check_eq("run_bound", n, -1);
    repeat (GAP + 2) step();
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    apply_reset();

    for (int k = 0; k < 4; k++) gen_pkt(k, 1, 11'(k * 37 + 5));
    run_until_idle(200);

    gen_pkt(2, 3, {3'd6, 8'hC3});
    run_until_idle(200);

    force_gap = 5;
    gen_pkt(1, 2, {3'd2, 8'h5A});
    run_until_idle(200);
    force_gap = 0;

    stall_pct = 20;
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(1) == 1)
          for (int p = 0; p < $urandom_range(2, 1); p++)
            gen_pkt(k, $urandom_range(5, 1), 11'($urandom));
      run_until_idle(2000);
    end

    stall_pct = 0;
    gen_pkt(3, 4, {3'd1, 8'h33});
    n = 0;
    while (bq[3].size() > 2 && n < 50) begin step(); n++; end
    check_eq("pre_reset_progress", bq[3].size(), 2);
    apply_reset();
    gen_pkt(3, 2, {3'd3, 8'h77});
    gen_pkt(0, 2, {3'd4, 8'h11});
    run_until_idle(200);

    gen_pkt(0, 3, {3'd5, 8'hA0});
    gen_pkt(1, 1, {3'd7, 8'hB1});
    freeze_lane = 0;
`ifdef SCREEN_ARB_TIMEOUT_EN
    run_until_idle(400);
`else
    n = 0;
    while (!pkt_open && n < 50) begin step(); n++; end
    repeat (100) step();
    check_eq("hold_grant", o_grant_lane, 0);
    check_eq("hold_ready", o_lane_ready, 4'b0001);
    freeze_lane = -1;
    hold[0] = 0;
    run_until_idle(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
